rv64g_l1_bank_resp_router: RTL and testbench

- Per-bank response side of the L1 scalar/vector bank arbitration path.
- Tracks which port won each bank access, delays that tag to match the bank's read latency, and returns bank read data to the scalar port or to a buffered, backpressurable vector port.
- Produces a credit signal that the bank arbiter's vector request path must honour, so vector read data is never dropped.

---
 rtl/rv64g_l1_bank_resp_router_pkg.sv | 15 +
 rtl/rv64g_l1_resp_fifo.sv | 68 ++++++
 rtl/rv64g_l1_bank_resp_router.sv | 144 ++++++++++++++
 tb/tb_rv64g_l1_bank_resp_router.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64g_l1_bank_resp_router_pkg.sv
// Shared L1 parameters for the bank response path.
//   L1_WORD_W : bank data word width
//   L1_VID_W  : default width of the vector request ID
//   is_read() : classifies an accepted bank access as a tracked read
package rv64g_l1_bank_resp_router_pkg;

  localparam int unsigned L1_WORD_W = 64;
  localparam int unsigned L1_VID_W  = 4;

  // Data writes and tag/state writes (including broadcasts) return nothing.
  function automatic logic is_read(input logic valid, input logic we, input logic tag_we);
    return valid & ~we & ~tag_we;
  endfunction

endpackage

// File: rtl/rv64g_l1_resp_fifo.sv
// First-word-fall-through FIFO for buffered vector read responses.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/push_data_i : write one entry
//   pop_i         : consume the head (ignored when empty)
//   valid_o/data_o: head entry, data is zero while empty
//   count_o       : current occupancy
module rv64g_l1_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 68,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths stay within the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (occ == '0);
  assign full    = (occ == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem[rd_ptr];
  assign count_o = occ;

endmodule

// File: rtl/rv64g_l1_bank_resp_router.sv
// Per-bank response router for the L1 scalar/vector arbitration path.
// Tracks the winner of every accepted bank read through a BANK_LAT-deep
// pipeline, then returns bank_rdata_i either to the scalar port (registered
// one-cycle pulse) or into a backpressurable vector FIFO. A credit counter
// (vector reads in flight + FIFO occupancy) gates further vector reads.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   issue_*_i               : access accepted by the bank arbiter this cycle
//   bank_rdata_i            : read data, valid BANK_LAT cycles after issue
//   scalar_resp_*_o         : scalar read return
//   vec_resp_*              : vector FIFO head with ready/valid handshake
//   vec_credit_ok_o         : a vector read may be issued this cycle
//   vec_overflow_o          : sticky, vector read issued without credit
//   busy_o                  : read in flight or vector FIFO non-empty
module rv64g_l1_bank_resp_router
  import rv64g_l1_bank_resp_router_pkg::*;
#(
  parameter int unsigned BANK_LAT = 1,
  parameter int unsigned VQ_DEPTH = 4,
  parameter int unsigned VID_W    = L1_VID_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  input  logic                 issue_we_i,
  input  logic                 issue_tag_we_i,
  input  logic                 issue_is_vec_i,
  input  logic [VID_W-1:0]     issue_vid_i,
  input  logic [L1_WORD_W-1:0] bank_rdata_i,
  output logic                 scalar_resp_valid_o,
  output logic [L1_WORD_W-1:0] scalar_resp_data_o,
  output logic                 vec_resp_valid_o,
  input  logic                 vec_resp_ready_i,
  output logic [L1_WORD_W-1:0] vec_resp_data_o,
  output logic [VID_W-1:0]     vec_resp_vid_o,
  output logic                 vec_credit_ok_o,
  output logic                 vec_overflow_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W  = $clog2(VQ_DEPTH + 1);
  localparam int unsigned FIFO_W = L1_WORD_W + VID_W;
  localparam int unsigned FCNT_W = $clog2(VQ_DEPTH + 1);

  logic             pipe_valid [BANK_LAT];
  logic             pipe_vec   [BANK_LAT];
  logic [VID_W-1:0] pipe_vid   [BANK_LAT];

  logic              rd_issue;
  logic              vec_rd;
  logic              track;
  logic              vec_inc;
  logic              head_valid;
  logic              head_vec;
  logic              scalar_hit;
  logic              vec_push;
  logic              vec_pop;
  logic              pipe_any;
  logic [CNT_W-1:0]  cnt;
  logic              overflow;
  logic              scalar_valid;
  logic [L1_WORD_W-1:0] scalar_data;
  logic              fifo_valid;
  logic [FIFO_W-1:0] fifo_data;
  logic [FCNT_W-1:0] fifo_count;

  assign rd_issue        = is_read(issue_valid_i, issue_we_i, issue_tag_we_i);
  assign vec_rd          = rd_issue & issue_is_vec_i;
  assign vec_credit_ok_o = (cnt < CNT_W'(VQ_DEPTH));
  // A vector read without credit is dropped here so its data can never
  // reach a FIFO that has no room reserved for it.
  assign vec_inc         = vec_rd & vec_credit_ok_o;
  assign track           = rd_issue & (~issue_is_vec_i | vec_credit_ok_o);

  assign head_valid = pipe_valid[BANK_LAT-1];
  assign head_vec   = pipe_vec[BANK_LAT-1];
  assign scalar_hit = head_valid & ~head_vec;
  assign vec_push   = head_valid & head_vec;
  assign vec_pop    = fifo_valid & vec_resp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BANK_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_vec[i]   <= 1'b0;
        pipe_vid[i]   <= '0;
      end
    end else begin
      pipe_valid[0] <= track;
      pipe_vec[0]   <= issue_is_vec_i;
      pipe_vid[0]   <= issue_vid_i;
      for (int unsigned i = 1; i < BANK_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_vec[i]   <= pipe_vec[i-1];
        pipe_vid[i]   <= pipe_vid[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt          <= '0;
      overflow     <= 1'b0;
      scalar_valid <= 1'b0;
      scalar_data  <= '0;
    end else begin
      unique case ({vec_inc, vec_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (vec_rd && !vec_credit_ok_o) overflow <= 1'b1;
      scalar_valid <= scalar_hit;
      if (scalar_hit) scalar_data <= bank_rdata_i;
    end
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int unsigned i = 0; i < BANK_LAT; i++) pipe_any = pipe_any | pipe_valid[i];
  end

  rv64g_l1_resp_fifo #(
    .DEPTH(VQ_DEPTH),
    .WIDTH(FIFO_W)
  ) u_vec_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (vec_push),
    .push_data_i({pipe_vid[BANK_LAT-1], bank_rdata_i}),
    .pop_i      (vec_pop),
    .valid_o    (fifo_valid),
    .data_o     (fifo_data),
    .count_o    (fifo_count)
  );

  assign scalar_resp_valid_o = scalar_valid;
  assign scalar_resp_data_o  = scalar_data;
  assign vec_resp_valid_o    = fifo_valid;
  assign {vec_resp_vid_o, vec_resp_data_o} = fifo_data;
  assign vec_overflow_o      = overflow;
  assign busy_o              = pipe_any | (fifo_count != '0);

endmodule

// File: tb/tb_rv64g_l1_bank_resp_router.sv
module tb_rv64g_l1_bank_resp_router;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_we;
  logic        issue_tag_we;
  logic        issue_is_vec;
  logic [3:0]  issue_vid;
  logic [63:0] bank_rdata;
  logic        scalar_valid;
  logic [63:0] scalar_data;
  logic        vec_valid;
  logic        vec_ready;
  logic [63:0] vec_data;
  logic [3:0]  vec_vid;
  logic        credit_ok;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] DSC = 64'hDEAD_BEEF_0000_0001;

  rv64g_l1_bank_resp_router #(
    .BANK_LAT(2),
    .VQ_DEPTH(4),
    .VID_W(4)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .issue_valid_i      (issue_valid),
    .issue_we_i         (issue_we),
    .issue_tag_we_i     (issue_tag_we),
    .issue_is_vec_i     (issue_is_vec),
    .issue_vid_i        (issue_vid),
    .bank_rdata_i       (bank_rdata),
    .scalar_resp_valid_o(scalar_valid),
    .scalar_resp_data_o (scalar_data),
    .vec_resp_valid_o   (vec_valid),
    .vec_resp_ready_i   (vec_ready),
    .vec_resp_data_o    (vec_data),
    .vec_resp_vid_o     (vec_vid),
    .vec_credit_ok_o    (credit_ok),
    .vec_overflow_o     (overflow),
    .busy_o             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [3:0] vid, input logic [63:0] data);
    chk({tag, "_valid"}, {63'd0, vec_valid}, 64'd1);
    chk({tag, "_vid"}, {60'd0, vec_vid}, {60'd0, vid});
    chk({tag, "_data"}, vec_data, data);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_we     = 1'b0;
    issue_tag_we = 1'b0;
    issue_is_vec = 1'b0;
    issue_vid    = 4'd0;
  endtask

  task automatic vec_issue(input logic [3:0] vid);
    issue_valid  = 1'b1;
    issue_we     = 1'b0;
    issue_tag_we = 1'b0;
    issue_is_vec = 1'b1;
    issue_vid    = vid;
  endtask

  task automatic sc_issue();
    issue_valid  = 1'b1;
    issue_we     = 1'b0;
    issue_tag_we = 1'b0;
    issue_is_vec = 1'b0;
    issue_vid    = 4'd0;
  endtask

  initial begin
    rst_n      = 1'b0;
    vec_ready  = 1'b0;
    bank_rdata = '0;
    idle();
    #2;
    chk("rst_scalar_valid", {63'd0, scalar_valid}, 64'd0);
    chk("rst_scalar_data", scalar_data, 64'd0);
    chk("rst_vec_valid", {63'd0, vec_valid}, 64'd0);
    chk("rst_vec_data", vec_data, 64'd0);
    chk("rst_credit", {63'd0, credit_ok}, 64'd1);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();

    // Scalar read: issue at T, data at T+2, response only at T+3.
    sc_issue();
    cyc();
    idle();
    chk("sc_t1_valid", {63'd0, scalar_valid}, 64'd0);
    chk("sc_t1_busy", {63'd0, busy}, 64'd1);
    cyc();
    bank_rdata = DSC;
    chk("sc_t2_valid", {63'd0, scalar_valid}, 64'd0);
    cyc();
    bank_rdata = '0;
    chk("sc_t3_valid", {63'd0, scalar_valid}, 64'd1);
    chk("sc_t3_data", scalar_data, DSC);
    chk("sc_t3_vec", {63'd0, vec_valid}, 64'd0);
    cyc();
    chk("sc_t4_valid", {63'd0, scalar_valid}, 64'd0);

    // Vector reads 3,5,7 with ready low; write and tag issues must not count.
    vec_issue(4'd3);
    cyc();
    vec_issue(4'd5);
    cyc();
    vec_issue(4'd7);
    bank_rdata = 64'h3333;
    cyc();
    idle();
    bank_rdata = 64'h5555;
    chk_head("v3a", 4'd3, 64'h3333);
    cyc();
    bank_rdata = 64'h7777;
    issue_valid = 1'b1; issue_we = 1'b1; issue_is_vec = 1'b1; issue_vid = 4'd1;
    cyc();
    bank_rdata = '0;
    issue_we = 1'b0; issue_tag_we = 1'b1;
    chk("v_cnt3_credit", {63'd0, credit_ok}, 64'd1);
    cyc();
    idle();
    bank_rdata = 64'hBAD1;
    chk("wr_credit", {63'd0, credit_ok}, 64'd1);
    chk_head("v3b", 4'd3, 64'h3333);
    cyc();
    bank_rdata = 64'hBAD2;
    chk("tag_credit", {63'd0, credit_ok}, 64'd1);
    chk_head("v3c", 4'd3, 64'h3333);
    vec_issue(4'd9);
    cyc();
    idle();
    bank_rdata = '0;
    chk("v_cnt4_credit", {63'd0, credit_ok}, 64'd0);
    cyc();
    bank_rdata = 64'h9999;
    cyc();
    bank_rdata = '0;
    chk_head("v3d", 4'd3, 64'h3333);
    chk("v_full_credit", {63'd0, credit_ok}, 64'd0);
    vec_ready = 1'b1;
    cyc();
    // Issue together with a pop: count stays at 3.
    chk_head("v5", 4'd5, 64'h5555);
    chk("pop_credit", {63'd0, credit_ok}, 64'd1);
    vec_issue(4'd11);
    cyc();
    idle();
    chk("iss_pop_credit", {63'd0, credit_ok}, 64'd1);
    chk("iss_pop_ovf", {63'd0, overflow}, 64'd0);
    chk_head("v7", 4'd7, 64'h7777);
    cyc();
    bank_rdata = 64'hBBBB;
    chk_head("v9", 4'd9, 64'h9999);
    cyc();
    bank_rdata = '0;
    chk_head("v11_wrap", 4'd11, 64'hBBBB);
    cyc();
    chk("drain_valid", {63'd0, vec_valid}, 64'd0);
    chk("drain_credit", {63'd0, credit_ok}, 64'd1);
    chk("drain_busy", {63'd0, busy}, 64'd0);
    chk("wr_no_scalar", {63'd0, scalar_valid}, 64'd0);
    vec_ready = 1'b0;

    // Overflow: 4 credited reads, a 5th without credit is dropped.
    vec_issue(4'd1);
    cyc();
    vec_issue(4'd2);
    cyc();
    vec_issue(4'd3);
    bank_rdata = 64'hE1;
    cyc();
    vec_issue(4'd4);
    bank_rdata = 64'hE2;
    chk("ov_cnt3_credit", {63'd0, credit_ok}, 64'd1);
    cyc();
    vec_issue(4'd15);
    bank_rdata = 64'hE3;
    chk("ov_cnt4_credit", {63'd0, credit_ok}, 64'd0);
    chk("ov_before", {63'd0, overflow}, 64'd0);
    cyc();
    idle();
    bank_rdata = 64'hE4;
    chk("ov_set", {63'd0, overflow}, 64'd1);
    cyc();
    bank_rdata = 64'hBAD3;
    chk("ov_credit", {63'd0, credit_ok}, 64'd0);
    cyc();
    bank_rdata = '0;
    chk("ov_sticky1", {63'd0, overflow}, 64'd1);
    chk_head("o1", 4'd1, 64'hE1);
    vec_ready = 1'b1;
    cyc();
    chk_head("o2", 4'd2, 64'hE2);
    chk("ov_pop_credit", {63'd0, credit_ok}, 64'd1);
    cyc();
    chk_head("o3", 4'd3, 64'hE3);
    cyc();
    chk_head("o4", 4'd4, 64'hE4);
    cyc();
    chk("ov_drain_valid", {63'd0, vec_valid}, 64'd0);
    chk("ov_sticky2", {63'd0, overflow}, 64'd1);
    chk("ov_drain_busy", {63'd0, busy}, 64'd0);
    vec_ready = 1'b0;

    // Reset with 2 FIFO entries and 2 reads in flight.
    vec_issue(4'd6);
    cyc();
    vec_issue(4'd8);
    cyc();
    vec_issue(4'd10);
    bank_rdata = 64'hF6;
    cyc();
    sc_issue();
    bank_rdata = 64'hF8;
    cyc();
    idle();
    bank_rdata = 64'hF10;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    chk_head("pre_rst", 4'd6, 64'hF6);
    rst_n = 1'b0;
    #1;
    chk("ar_vec_valid", {63'd0, vec_valid}, 64'd0);
    chk("ar_vec_data", vec_data, 64'd0);
    chk("ar_vec_vid", {60'd0, vec_vid}, 64'd0);
    chk("ar_credit", {63'd0, credit_ok}, 64'd1);
    chk("ar_overflow", {63'd0, overflow}, 64'd0);
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_scalar_valid", {63'd0, scalar_valid}, 64'd0);
    chk("ar_scalar_data", scalar_data, 64'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_scalar", {63'd0, scalar_valid}, 64'd0);
      chk("post_rst_vec", {63'd0, vec_valid}, 64'd0);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
    end
    bank_rdata = '0;
    chk("post_rst_credit", {63'd0, credit_ok}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
